// File: rtl/instruction_decoder.sv
// Instruction register, zero flag, reset-release sequencer and jump delay-slot handling.
// Define INSTR_DECODER_FLUSH_EN to squash the delay-slot word after a taken jump.
module instruction_decoder #(
  parameter int unsigned RST_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       sync_reset,
  output logic       jmp,
  output logic       jmp_nz,
  output logic       dont_jmp,
  output logic [3:0] jmp_addr,
  output logic [7:0] ir,
  output logic       reg_we,
  output logic [2:0] reg_sel,
  output logic [3:0] imm,
  output logic       alu_en,
  output logic [2:0] alu_op,
  output logic [2:0] alu_src
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IR_W   = 8;
  localparam logic [IR_W-1:0] IR_RST = 8'hE0;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef INSTR_DECODER_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             zf_q, zf_d;

  logic             run_c;
  logic             is_ld_c, is_alu_c, is_jmp_c, is_jnz_c;
`ifdef INSTR_DECODER_FLUSH_EN
  logic             taken_c;
`endif

  assign ir         = ir_q;
  assign dont_jmp   = zf_q;
  assign sync_reset = (state_q == ST_HOLD);
  assign run_c      = (state_q == ST_RUN);

  // Field decode of the instruction register; strobes live only in RUN
  always_comb begin
    is_ld_c  = ~ir_q[7];
    is_alu_c = (ir_q[7:6] == 2'b10);
    is_jmp_c = (ir_q[7:4] == 4'hC);
    is_jnz_c = (ir_q[7:4] == 4'hD);

    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    jmp_addr = 4'h0;
    reg_we   = 1'b0;
    reg_sel  = 3'd0;
    imm      = 4'h0;
    alu_en   = 1'b0;
    alu_op   = 3'd0;
    alu_src  = 3'd0;

    if (run_c) begin
      jmp_addr = ir_q[3:0];
      jmp      = is_jmp_c;
      jmp_nz   = is_jnz_c;
      if (is_ld_c) begin
        reg_we  = 1'b1;
        reg_sel = ir_q[6:4];
        imm     = ir_q[3:0];
      end
      if (is_alu_c) begin
        alu_en  = 1'b1;
        alu_op  = ir_q[5:3];
        alu_src = ir_q[2:0];
      end
    end
  end

`ifdef INSTR_DECODER_FLUSH_EN
  assign taken_c = jmp | (jmp_nz & ~zf_q);
`endif

  // Next-state, counter, instruction register and flag update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    zf_d    = zf_q;

    case (state_q)
      ST_HOLD: begin
        ir_d = IR_RST;
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        ir_d = pm_data;
        if (alu_en) begin
          zf_d = alu_zero;
        end
`ifdef INSTR_DECODER_FLUSH_EN
        if (taken_c) begin
          state_d = ST_FLUSH;
        end
`endif
      end
`ifdef INSTR_DECODER_FLUSH_EN
      // Delay-slot word is captured but never decoded
      ST_FLUSH: begin
        ir_d    = pm_data;
        state_d = ST_RUN;
      end
`endif
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        ir_d    = IR_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      ir_q    <= IR_RST;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Randomized bench for instruction_decoder against a behavioural model of the decode,
// hold-off counter, zero flag and delay-slot squash.
module tb_instruction_decoder;

  localparam int unsigned RST_HOLD = 2;
`ifdef INSTR_DECODER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef struct packed {
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       reg_we;
    logic [2:0] reg_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic [2:0] alu_op;
    logic [2:0] alu_src;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] pm_data = 8'h00;
  logic       alu_zero = 1'b0;
  logic       sync_reset, jmp, jmp_nz, dont_jmp;
  logic [3:0] jmp_addr;
  logic [7:0] ir;
  logic       reg_we;
  logic [2:0] reg_sel;
  logic [3:0] imm;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [2:0] alu_src;

  int vectors = 0;
  int miscompares = 0;

  instruction_decoder #(.RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .alu_zero(alu_zero),
    .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
    .jmp_addr(jmp_addr), .ir(ir), .reg_we(reg_we), .reg_sel(reg_sel), .imm(imm),
    .alu_en(alu_en), .alu_op(alu_op), .alu_src(alu_src)
  );

  always #5 clk = ~clk;

  // Model state: remaining hold edges, instruction word, zero flag, squash of current word
  int         m_hold   = int'(RST_HOLD);
  logic [7:0] m_ir     = 8'hE0;
  logic       m_flag   = 1'b0;
  bit         m_squash = 1'b0;
  exp_t       cur, act;

  function automatic exp_t expect_out(input logic [7:0] i, input bit active, input bit hold);
    exp_t e;
    e = '0;
    e.sync_reset = hold;
    if (active) begin
      e.jmp_addr = 4'(i % 16);
      if (i < 8'h80) begin
        e.reg_we  = 1'b1;
        e.reg_sel = 3'(i / 16);
        e.imm     = 4'(i % 16);
      end else if (i < 8'hC0) begin
        e.alu_en  = 1'b1;
        e.alu_op  = 3'((i / 8) % 8);
        e.alu_src = 3'(i % 8);
      end else if (i < 8'hD0) begin
        e.jmp = 1'b1;
      end else if (i < 8'hE0) begin
        e.jmp_nz = 1'b1;
      end
    end
    return e;
  endfunction

  assign cur = expect_out(m_ir, (m_hold == 0) && !m_squash, m_hold > 0);
  assign act = {sync_reset, jmp, jmp_nz, jmp_addr, reg_we, reg_sel, imm,
                alu_en, alu_op, alu_src};

  // Reference model advance
  initial begin
    bit nxt_squash;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_hold   = int'(RST_HOLD);
        m_ir     = 8'hE0;
        m_flag   = 1'b0;
        m_squash = 1'b0;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
        m_ir   = 8'hE0;
      end else begin
        nxt_squash = FLUSH_EN && (cur.jmp || (cur.jmp_nz && !m_flag));
        if (cur.alu_en) m_flag = alu_zero;
        m_squash = nxt_squash;
        m_ir     = pm_data;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (act !== cur) begin
        miscompares++;
        $display("FAIL outputs ir=%h: got %h expected %h", m_ir, act, cur);
      end
      vectors++;
      if (ir !== m_ir) begin
        miscompares++;
        $display("FAIL ir: got %h expected %h", ir, m_ir);
      end
      vectors++;
      if (dont_jmp !== m_flag) begin
        miscompares++;
        $display("FAIL dont_jmp: got %b expected %b", dont_jmp, m_flag);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Present one word and zero flag, let one edge pass, return at the following falling edge
  task automatic step(input logic [7:0] d, input logic z);
    pm_data  = d;
    alu_zero = z;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    lit("rst_sync", 8'(sync_reset), 8'h01);
    lit("rst_ir", ir, 8'hE0);
    lit("rst_flag", 8'(dont_jmp), 8'h00);
    lit("rst_we", 8'(reg_we), 8'h00);
    reset_n = 1'b1;

    step(8'h11, 1'b0);
    lit("hold1_sync", 8'(sync_reset), 8'h01);
    lit("hold1_ir", ir, 8'hE0);
    step(8'h22, 1'b0);
    lit("hold2_sync", 8'(sync_reset), 8'h00);
    lit("hold2_ir", ir, 8'hE0);

    step(8'h3A, 1'b0);
    lit("ld_we", 8'(reg_we), 8'h01);
    lit("ld_sel", 8'(reg_sel), 8'h03);
    lit("ld_imm", 8'(imm), 8'h0A);
    lit("ld_alu", 8'(alu_en), 8'h00);

    step(8'hC5, 1'b0);
    lit("jmp", 8'(jmp), 8'h01);
    lit("jmp_addr", 8'(jmp_addr), 8'h05);
    step(8'h3A, 1'b0);
    lit("jmp_slot_we", 8'(reg_we), FLUSH_EN ? 8'h00 : 8'h01);

    step(8'h88, 1'b0);
    lit("alu_en", 8'(alu_en), 8'h01);
    lit("alu_op", 8'(alu_op), 8'h01);
    step(8'hD7, 1'b1);
    lit("jnz_z_flag", 8'(dont_jmp), 8'h01);
    lit("jnz_z_req", 8'(jmp_nz), 8'h01);
    lit("jnz_z_addr", 8'(jmp_addr), 8'h07);
    step(8'h3A, 1'b0);
    lit("jnz_z_slot_we", 8'(reg_we), 8'h01);

    step(8'h88, 1'b0);
    step(8'hD7, 1'b0);
    lit("jnz_nz_flag", 8'(dont_jmp), 8'h00);
    lit("jnz_nz_req", 8'(jmp_nz), 8'h01);
    step(8'h3A, 1'b0);
    lit("jnz_nz_slot_we", 8'(reg_we), FLUSH_EN ? 8'h00 : 8'h01);

    #1 reset_n = 1'b0;
    #1;
    lit("async_sync", 8'(sync_reset), 8'h01);
    lit("async_ir", ir, 8'hE0);
    lit("async_we", 8'(reg_we), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h3A, 1'b0);
    lit("rehold1_sync", 8'(sync_reset), 8'h01);
    step(8'h3A, 1'b0);
    lit("rehold2_sync", 8'(sync_reset), 8'h00);
    lit("rehold2_ir", ir, 8'hE0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) d = {3'b110, 1'($urandom), 4'($urandom)};
        step(d, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
